// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: default geometry and loader state encodings shared by the imem loader.
package imem_loader_pkg;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_ROM_BLOCKS_NUM = 128;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts stream bytes into a big-endian word, left-justified and zero-padded.
module imem_loader_byte_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [7:0]            i_byte,
    output logic                  o_full,
    output logic [DATA_WIDTH-1:0] o_word
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(NB + 1);
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (i_shift) begin
            shreg <= (shreg << 8) | DATA_WIDTH'(i_byte);
            cnt   <= cnt + 1'b1;
        end
    end
    assign o_full = cnt == CW'(NB - 1);
    // A short final word is moved up so its first byte lands in the top lane.
    assign o_word = shreg << (8 * (NB - int'(cnt)));
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a boot byte stream into words, writes them to imem, holds the CPU until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int ROM_BLOCKS_NUM = DEF_ROM_BLOCKS_NUM
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    input  logic                  i_last,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);
    state_t                state, nxt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  last_q, accept, start_go, in_range, full;
    assign accept   = i_byte_valid & o_byte_ready;
    assign start_go = i_start & (state == IDLE || state == DONE);
    assign in_range = word_idx < ADDR_WIDTH'(ROM_BLOCKS_NUM);
    imem_loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (start_go || state == WRITE),
        .i_shift (accept && state == RECV),
        .i_byte  (i_byte),
        .o_full  (full),
        .o_word  (o_wr_data)
    );
    assign o_wr_addr = word_idx;
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = i_start ? RECV : state;
            RECV:       nxt = (accept && (full || i_last)) ? WRITE : RECV;
            WRITE:      nxt = last_q ? DONE : (in_range ? RECV : DRAIN);
            DRAIN:      nxt = (accept && i_last) ? DONE : DRAIN;
            default:    nxt = IDLE;
        endcase
    end
    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            word_idx     <= '0;
            last_q       <= 1'b0;
            o_overflow   <= 1'b0;
            o_byte_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_cpu_hold   <= 1'b1;
        end else begin
            state <= nxt;
            if (start_go) begin
                word_idx   <= '0;
                o_overflow <= 1'b0;
            end
            if (state == RECV && nxt == WRITE)
                last_q <= i_last;
            if (state == WRITE) begin
                if (in_range)
                    word_idx <= word_idx + 1'b1;
                else
                    o_overflow <= 1'b1;
            end
            o_byte_ready <= nxt == RECV || nxt == DRAIN;
            o_busy       <= nxt == RECV || nxt == WRITE || nxt == DRAIN;
            o_done       <= nxt == DONE;
            o_cpu_hold   <= nxt != DONE;
            o_wr_en      <= nxt == WRITE && in_range;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed byte images with a write scoreboard checked by an independent monitor.
module tb_imem_loader;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_byte_valid = 1'b0, i_last = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready, o_wr_en, o_cpu_hold, o_busy, o_done, o_overflow;
    logic [31:0] o_wr_addr, o_wr_data;
    logic [63:0] exp_q[$];
    logic [7:0]  img[$];
    logic        prev_wr = 1'b0;
    int          checks = 0, errors = 0;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_BLOCKS_NUM(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_byte_valid(i_byte_valid),
        .i_byte(i_byte), .i_last(i_last), .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_cpu_hold(o_cpu_hold),
        .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_wr_en) begin
            chk("strobe_width", 64'(prev_wr), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", o_wr_addr, o_wr_data);
            end else
                chk("write", {o_wr_addr, o_wr_data}, exp_q.pop_front());
        end
        prev_wr = o_wr_en;
    end

    task automatic send(input logic [7:0] b, input logic l, input int gap);
        int n = 0;
        i_byte_valid = 1'b1;
        i_byte = b;
        i_last = l;
        while (!o_byte_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(o_byte_ready), 64'd1);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        i_last = 1'b0;
        repeat (gap) @(negedge i_clk);
    endtask

    task automatic send_img(input int gap);
        foreach (img[i]) send(img[i], i == img.size() - 1, gap);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic finish_load(input string name, input logic ovf);
        int n = 0;
        while (!o_done && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk({name, "_done"}, 64'(o_done), 64'd1);
        chk({name, "_hold"}, 64'(o_cpu_hold), 64'd0);
        chk({name, "_busy"}, 64'(o_busy), 64'd0);
        chk({name, "_ready"}, 64'(o_byte_ready), 64'd0);
        chk({name, "_overflow"}, 64'(o_overflow), 64'(ovf));
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_hold"}, 64'(o_cpu_hold), 64'd1);
        chk({name, "_ready"}, 64'(o_byte_ready), 64'd0);
        chk({name, "_busy"}, 64'(o_busy), 64'd0);
        chk({name, "_done"}, 64'(o_done), 64'd0);
        chk({name, "_overflow"}, 64'(o_overflow), 64'd0);
        chk({name, "_wr_en"}, 64'(o_wr_en), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        chk_reset("reset");
        // Two full words, valid every cycle
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'h9ABCDEF0});
        pulse_start();
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_hold", 64'(o_cpu_hold), 64'd1);
        send_img(0);
        finish_load("t1", 1'b0);
        // Partial final word is left-justified
        img = '{8'hAA, 8'hBB};
        exp_q.push_back({32'd0, 32'hAABB0000});
        pulse_start();
        send_img(0);
        finish_load("t2", 1'b0);
        // Valid gaps do not change the writes
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        exp_q.push_back({32'd0, 32'h12345678});
        exp_q.push_back({32'd1, 32'h9ABCDEF0});
        pulse_start();
        send_img(3);
        finish_load("t3", 1'b0);
        // Third word exceeds the 2-word ROM and ends the image
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        exp_q.push_back({32'd0, 32'h01020304});
        exp_q.push_back({32'd1, 32'h05060708});
        pulse_start();
        chk("t4_overflow_cleared", 64'(o_overflow), 64'd0);
        send_img(0);
        finish_load("t4", 1'b1);
        // Overflow without last on the third word: remaining bytes drained
        exp_q.push_back({32'd0, 32'h01020304});
        exp_q.push_back({32'd1, 32'h05060708});
        pulse_start();
        chk("t4b_overflow_cleared", 64'(o_overflow), 64'd0);
        foreach (img[i]) send(img[i], 1'b0, 0);
        @(negedge i_clk);
        chk("t4b_drain_ready", 64'(o_byte_ready), 64'd1);
        chk("t4b_drain_overflow", 64'(o_overflow), 64'd1);
        chk("t4b_drain_done", 64'(o_done), 64'd0);
        send(8'hEE, 1'b0, 0);
        send(8'hFF, 1'b1, 0);
        finish_load("t4b", 1'b1);
        // Reset mid-word aborts without a write
        pulse_start();
        send(8'h55, 1'b0, 0);
        send(8'h66, 1'b0, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk_reset("t5_reset");
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back({32'd0, 32'h11223344});
        pulse_start();
        send_img(0);
        finish_load("t5", 1'b0);
        // Start during RECV is ignored; start in DONE restarts at word 0
        exp_q.push_back({32'd0, 32'h11223344});
        exp_q.push_back({32'd1, 32'h55667788});
        pulse_start();
        foreach (img[i]) send(img[i], 1'b0, 0);
        send(8'h55, 1'b0, 0);
        send(8'h66, 1'b0, 0);
        pulse_start();
        chk("t6_ignored_busy", 64'(o_busy), 64'd1);
        send(8'h77, 1'b0, 0);
        send(8'h88, 1'b1, 0);
        finish_load("t6", 1'b0);
        exp_q.push_back({32'd0, 32'h99AA0000});
        pulse_start();
        chk("t6_restart_done_cleared", 64'(o_done), 64'd0);
        send(8'h99, 1'b0, 0);
        send(8'hAA, 1'b1, 0);
        finish_load("t6_restart", 1'b0);
        repeat (3) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
